// File: rtl/ct_rmu_apb_master_if.sv
// Register-request, APB and response signals between the core-side request
// path, the RMU APB initiator and the RMU responder.
interface ct_rmu_apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 12
);

  // Command port
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [31:0]           req_wdata;

  // APB toward the RMU responder
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic                  psel_rmr;
  logic                  penable;
  logic                  pready_rmr;
  logic [31:0]           prdata_rmr;
  logic                  perr_rmr;

  // Response port
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // Initiator view
  modport master (
    input  req_vld, req_addr, req_write, req_wdata,
    input  pready_rmr, prdata_rmr, perr_rmr,
    input  rsp_rdy,
    output req_rdy,
    output paddr, pwrite, pwdata, psel_rmr, penable,
    output rsp_vld, rsp_rdata, rsp_err, rsp_timeout
  );

  // Requester / responder view
  modport slave (
    output req_vld, req_addr, req_write, req_wdata,
    output pready_rmr, prdata_rmr, perr_rmr,
    output rsp_rdy,
    input  req_rdy,
    input  paddr, pwrite, pwdata, psel_rmr, penable,
    input  rsp_vld, rsp_rdata, rsp_err, rsp_timeout
  );

endinterface

// File: rtl/ct_rmu_apb_master.sv
// APB initiator for the RMU register window: one request at a time, two-phase
// APB transfer with a watchdog that aborts transfers whose responder stalls.
module ct_rmu_apb_master #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TO_CYCLES  = 255
) (
  input  logic                       apb_clk,
  input  logic                       apbrst,
  ct_rmu_apb_master_if.master        bus
);

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;

  logic                  accept_c;
  logic                  done_c;
  logic                  timeout_c;

  logic                  req_rdy_nxt;
  logic                  psel_nxt;
  logic                  penable_nxt;
  logic                  rsp_vld_nxt;

  logic                  req_rdy_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_vld_q;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;

  logic [CNT_W-1:0]      cnt_q;

  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  // Transfer events: acceptance in IDLE, completion or abort in ACCESS
  assign accept_c  = (state == ST_IDLE) && bus.req_vld;
  assign timeout_c = (state == ST_ACCESS) && !bus.pready_rmr && (cnt_q == CNT_LIMIT);
  assign done_c    = (state == ST_ACCESS) && (bus.pready_rmr || timeout_c);

  // Next state and next values of the state-decoded control outputs
  always_comb begin
    state_nxt   = state;
    req_rdy_nxt = 1'b0;
    psel_nxt    = 1'b0;
    penable_nxt = 1'b0;
    rsp_vld_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.req_vld) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done_c) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    case (state_nxt)
      ST_IDLE:   req_rdy_nxt = 1'b1;
      ST_SETUP:  psel_nxt    = 1'b1;
      ST_ACCESS: begin
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
      end
      ST_RESP:   rsp_vld_nxt = 1'b1;
      default:   req_rdy_nxt = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge apb_clk) begin
    if (apbrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control outputs, registered alongside the state so they mirror it exactly
  always_ff @(posedge apb_clk) begin
    if (apbrst) begin
      req_rdy_q <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      req_rdy_q <= req_rdy_nxt;
      psel_q    <= psel_nxt;
      penable_q <= penable_nxt;
      rsp_vld_q <= rsp_vld_nxt;
    end
  end

  // Address/direction/data latched on acceptance, held for the whole transfer
  always_ff @(posedge apb_clk) begin
    if (apbrst) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (accept_c) begin
      paddr_q  <= bus.req_addr;
      pwrite_q <= bus.req_write;
      pwdata_q <= bus.req_wdata;
    end
  end

  // Watchdog: counts ACCESS cycles without ready, saturating rather than wrapping
  always_ff @(posedge apb_clk) begin
    if (apbrst) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= '0;
    end else if ((state == ST_ACCESS) && !done_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response capture; ready takes priority over a same-cycle watchdog expiry
  always_ff @(posedge apb_clk) begin
    if (apbrst) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if ((state == ST_ACCESS) && bus.pready_rmr) begin
      rsp_rdata_q   <= pwrite_q ? 32'd0 : bus.prdata_rmr;
      rsp_err_q     <= bus.perr_rmr;
      rsp_timeout_q <= 1'b0;
    end else if (timeout_c) begin
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b1;
      rsp_timeout_q <= 1'b1;
    end
  end

  assign bus.req_rdy     = req_rdy_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.psel_rmr    = psel_q;
  assign bus.penable     = penable_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ct_rmu_apb_master.sv
// Bench for ct_rmu_apb_master: directed cases plus randomized transfers
// against a cycle-timeline reference model and a reactive APB responder.
module tb_ct_rmu_apb_master;

  localparam int AW = 12;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  ct_rmu_apb_master_if #(.ADDR_WIDTH(AW)) bus ();

  ct_rmu_apb_master #(
    .ADDR_WIDTH(AW),
    .TO_CYCLES (TO)
  ) dut (
    .apb_clk(clk),
    .apbrst (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // Reactive responder: ready after waits_cfg ACCESS cycles, noise otherwise
  int          waits_cfg = 0;
  logic [31:0] rdata_cfg = '0;
  logic        err_cfg   = 1'b0;
  logic [31:0] noise     = '0;
  int          acc_cnt   = 0;

  always @(posedge clk) begin
    noise <= $urandom;
    if (bus.psel_rmr && bus.penable && !bus.pready_rmr) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.pready_rmr = bus.psel_rmr && bus.penable && (acc_cnt == waits_cfg);
  assign bus.prdata_rmr = bus.pready_rmr ? rdata_cfg : noise;
  assign bus.perr_rmr   = bus.pready_rmr ? err_cfg : noise[0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ctl_now();
    return 64'({bus.req_rdy, bus.psel_rmr, bus.penable, bus.rsp_vld});
  endfunction

  function automatic logic [63:0] apb_now();
    return 64'({bus.paddr, bus.pwrite, bus.pwdata});
  endfunction

  function automatic logic [63:0] rsp_now();
    return 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
  endfunction

  // One transfer, started at a negedge while the DUT is idle. Expected timeline:
  // accepted at edge 0, SETUP cycle 1, ACCESS from cycle 2, response at cycle lat.
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                         input int waits, input logic perr, input logic [31:0] rd,
                         input int bp, input logic hold);
    int          lat;
    logic        to;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [63:0] exp_apb;
    logic [63:0] exp_ctl;

    to        = (waits >= TO);
    lat       = to ? TO + 2 : 3 + waits;
    exp_rdata = (to || wr) ? 32'd0 : rd;
    exp_err   = to ? 1'b1 : perr;
    exp_apb   = 64'({addr, wr, wd});

    waits_cfg = waits;
    rdata_cfg = rd;
    err_cfg   = perr;

    check("idle_ctl", ctl_now(), 64'(4'b1000));
    bus.req_vld   = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wd;
    bus.rsp_rdy   = 1'b0;

    for (int k = 1; k <= lat + bp + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          bus.req_addr  = AW'($urandom);
          bus.req_wdata = $urandom;
          bus.req_write = ~wr;
        end else begin
          bus.req_vld = 1'b0;
        end
      end
      if (k <= lat + bp) begin
        exp_ctl = 64'({1'b0, (k < lat), (k >= 2 && k < lat), (k >= lat)});
        check("ctl", ctl_now(), exp_ctl);
        check("apb", apb_now(), exp_apb);
        if (k >= lat) check("rsp", rsp_now(), 64'({exp_rdata, exp_err, to}));
        if (k == lat + bp) begin
          bus.rsp_rdy = 1'b1;
          bus.req_vld = 1'b0;
        end
      end else begin
        check("ret_idle", ctl_now(), 64'(4'b1000));
        bus.rsp_rdy = 1'b0;
      end
    end
  endtask

  // Reset asserted during ACCESS of a stalled transfer
  task automatic reset_mid();
    waits_cfg     = 100;
    bus.req_vld   = 1'b1;
    bus.req_addr  = 12'h3c4;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    bus.req_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_pre_access", ctl_now(), 64'(4'b0110));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_ctl", ctl_now(), 64'(4'b1000));
    check("rst_apb", apb_now(), 64'd0);
    check("rst_rsp", rsp_now(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_quiet", ctl_now(), 64'(4'b1000));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    rst           = 1'b1;
    bus.req_vld   = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_rdy   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", ctl_now(), 64'(4'b1000));
    check("reset_apb", apb_now(), 64'd0);
    check("reset_rsp", rsp_now(), 64'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_reset_ctl", ctl_now(), 64'(4'b1000));

    // Read, zero wait states
    run_txn(12'h010, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001, 0, 1'b0);
    // Write, three wait states
    run_txn(12'h024, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    // Dummy-style responder: one wait state, error, zero data
    run_txn(12'h100, 1'b0, 32'h0, 1, 1'b1, 32'h0, 0, 1'b0);
    // Watchdog abort
    run_txn(12'h200, 1'b0, 32'h0, 50, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    // Ready on the last ACCESS cycle before abort wins
    run_txn(12'h204, 1'b0, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 0, 1'b0);
    // Response backpressure with a pending request held during the transfer
    run_txn(12'h0ff, 1'b0, 32'h0, 2, 1'b1, 32'hCAFE_0042, 5, 1'b1);
    // Reset in ACCESS
    reset_mid();

    for (int n = 0; n < 60; n++) begin
      run_txn(AW'($urandom), 1'($urandom), $urandom, $urandom_range(0, 6),
              1'($urandom), $urandom, $urandom_range(0, 5), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
